// File: rtl/lfsr_interval_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_interval_ctrl
//
// Control stage in front of an LFSR terminal-count counter (DW03_lfsr_scnto).
// A job (seed + repetition count) is accepted over a valid/ready handshake.
// The block then alternates between a one-cycle seed load and a counting
// phase. Each counter terminal count ends one interval. After the programmed
// number of intervals a one-cycle irq is raised. A repetition count of zero
// runs free until abort.
//
// Optional feature macro: LFSR_INTERVAL_CTRL_PAUSE_EN
//   When defined, adds input `pause`, which freezes the counting phase.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active low
//   cfg_valid    in   job request
//   cfg_ready    out  job may be accepted this cycle
//   cfg_seed     in   LFSR start value, captured on accept
//   cfg_reps     in   number of intervals, 0 = free-running
//   abort        in   synchronous abort, highest priority
//   pause        in   (macro only) hold the counting phase
//   lfsr_data    out  seed to counter `data`
//   lfsr_load_n  out  active-low load to counter `load`
//   lfsr_cen     out  counter enable
//   lfsr_tercnt  in   counter terminal count
//   busy         out  job in progress
//   irq          out  one-cycle completion pulse
//   rep_count    out  intervals completed in the current job
// -----------------------------------------------------------------------------
module lfsr_interval_ctrl #(
  parameter int WIDTH = 8,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic             abort,
`ifdef LFSR_INTERVAL_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] lfsr_data,
  output logic             lfsr_load_n,
  output logic             lfsr_cen,
  input  logic             lfsr_tercnt,
  output logic             busy,
  output logic             irq,
  output logic [REP_W-1:0] rep_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [REP_W-1:0] rep_count_q, rep_count_d;
  logic [REP_W-1:0] rep_count_inc;
  logic             pause_run;

`ifdef LFSR_INTERVAL_CTRL_PAUSE_EN
  assign pause_run = pause;
`else
  assign pause_run = 1'b0;
`endif

  // Wraps naturally modulo 2^REP_W, which is the free-running behaviour.
  assign rep_count_inc = rep_count_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    reps_d      = reps_q;
    rep_count_d = rep_count_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid && !abort) begin
          seed_d      = cfg_seed;
          reps_d      = cfg_reps;
          rep_count_d = '0;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        // tercnt from the previous interval may still be high here; ignore it.
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!pause_run && lfsr_tercnt) begin
          rep_count_d = rep_count_inc;
          if ((reps_q != '0) && (rep_count_inc == reps_q)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything: no accept, no increment, back to IDLE.
    if (abort) begin
      state_d     = S_IDLE;
      seed_d      = seed_q;
      reps_d      = reps_q;
      rep_count_d = rep_count_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      seed_q      <= '0;
      reps_q      <= '0;
      rep_count_q <= '0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      reps_q      <= reps_d;
      rep_count_q <= rep_count_d;
    end
  end

  // Outputs decode the registered state; abort gates the counter-facing
  // strobes and irq in the same cycle so the counter never sees a late edge.
  assign cfg_ready   = (state_q == S_IDLE) && !abort;
  assign lfsr_load_n = !((state_q == S_LOAD) && !abort);
  assign lfsr_cen    = (state_q == S_RUN) && !abort && !pause_run;
  assign irq         = (state_q == S_DONE) && !abort;
  assign busy        = (state_q != S_IDLE);
  assign lfsr_data   = seed_q;
  assign rep_count   = rep_count_q;

endmodule

// File: tb/tb_lfsr_interval_ctrl.sv
module tb_lfsr_interval_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [7:0] cfg_seed = '0;
  logic [7:0] cfg_reps = '0;
  logic       abort = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] lfsr_data;
  logic       lfsr_load_n;
  logic       lfsr_cen;
  logic       lfsr_tercnt;
  logic       busy;
  logic       irq;
  logic [7:0] rep_count;

  int n_cmp = 0;
  int n_err = 0;

  // Counter stand-in: counts enabled cycles since the last load and reports
  // terminal count after `period` enabled cycles.
  int   period = 4;
  int   tc_cnt = 0;
  logic tc_force = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!lfsr_load_n)  tc_cnt <= 0;
    else if (lfsr_cen) tc_cnt <= tc_cnt + 1;
  end
  assign lfsr_tercnt = tc_force || (tc_cnt == period - 1);

  lfsr_interval_ctrl #(.WIDTH(8), .REP_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_seed    (cfg_seed),
    .cfg_reps    (cfg_reps),
    .abort       (abort),
`ifdef LFSR_INTERVAL_CTRL_PAUSE_EN
    .pause       (pause),
`endif
    .lfsr_data   (lfsr_data),
    .lfsr_load_n (lfsr_load_n),
    .lfsr_cen    (lfsr_cen),
    .lfsr_tercnt (lfsr_tercnt),
    .busy        (busy),
    .irq         (irq),
    .rep_count   (rep_count)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one job. k = busy-cycle index (0 = LOAD cycle) at which abort is
  // pulsed, or -1 for none. Expectations come from interval arithmetic:
  // interval i spans cycles i*(p+1) .. i*(p+1)+p, its tercnt at the last one.
  task automatic run_job(input logic [7:0] seed, input logic [7:0] reps,
                         input int p, input int k, input bit hold);
    int     cyc, loads, irqs, irq_cyc, bad_data, bad_abort, bad_ready;
    longint rr, exp_len, exp_cnt, exp_loads;
    cyc = 0; loads = 0; irqs = 0; irq_cyc = -1;
    bad_data = 0; bad_abort = 0; bad_ready = 0;
    period = p;
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_seed = seed; cfg_reps = reps; abort = 1'b0;
    @(negedge clk);
    check("accept_ready", cfg_ready, 1);
    @(posedge clk); #1;
    if (!hold) cfg_valid = 1'b0;
    cfg_seed = 8'($urandom);
    cfg_reps = 8'($urandom);
    while (1) begin
      abort = (cyc == k);
      @(negedge clk);
      if (!busy) break;
      if (!lfsr_load_n) begin
        loads++;
        if (lfsr_data !== seed) bad_data++;
      end
      if (irq) begin
        irqs++;
        irq_cyc = cyc;
      end
      if (abort && (lfsr_cen || !lfsr_load_n || irq)) bad_abort++;
      if (hold && cfg_ready) bad_ready++;
      cyc++;
      if (cyc > 3000) begin
        check("job_timeout", cyc, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    abort = 1'b0;

    rr = (reps == 0) ? 64'd1000000 : longint'(reps);
    if (k < 0) begin
      exp_len   = rr * (p + 1) + 1;
      exp_cnt   = rr % 256;
      exp_loads = rr;
    end else begin
      exp_len   = k + 1;
      exp_cnt   = ((k / (p + 1)) < rr ? (k / (p + 1)) : rr) % 256;
      exp_loads = ((k + p) / (p + 1)) < rr ? ((k + p) / (p + 1)) : rr;
    end
    check("busy_len", cyc, exp_len);
    check("load_pulses", loads, exp_loads);
    check("irq_count", irqs, (k < 0) ? 1 : 0);
    check("rep_count", rep_count, exp_cnt);
    check("load_data", bad_data, 0);
    check("data_held", lfsr_data, seed);
    if (k < 0) check("irq_cycle", irq_cyc, rr * (p + 1));
    if (k >= 0) check("abort_gating", bad_abort, 0);
    if (hold) check("ready_while_busy", bad_ready, 0);
    $display("job seed=%02h reps=%0d period=%0d abort_at=%0d len=%0d loads=%0d irqs=%0d rep_count=%0d",
             seed, reps, p, k, cyc, loads, irqs, rep_count);
  endtask

  initial begin
    int p, r, k;

    // Power-on reset
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ready", cfg_ready, 1);
    check("rst_load_n", lfsr_load_n, 1);
    check("rst_cen", lfsr_cen, 0);
    check("rst_data", lfsr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_irq", irq, 0);
    check("rst_rep_count", rep_count, 0);
    @(negedge clk) reset = 1'b1;

    // Single job from the plan
    run_job(8'h5A, 8'd3, 6, -1, 1'b0);

    // Abort coincident with the first tercnt
    run_job(8'hC3, 8'd2, 3, 3, 1'b0);

    // Abort in DONE suppresses irq
    run_job(8'h11, 8'd2, 2, 6, 1'b0);

    // Free-running wrap: 257 intervals then abort
    run_job(8'h77, 8'd0, 1, 257 * 2, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("free_hold", rep_count, 1);

    // Handshake: valid held through the job, one accept only
    run_job(8'h3C, 8'd1, 2, -1, 1'b1);
    @(posedge clk); #1;
    cfg_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    check("abort_valid_ready", cfg_ready, 0);
    @(posedge clk); #1;
    cfg_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_valid_busy", busy, 0);
    $display("handshake abort+valid busy=%0d", busy);

    // Reset mid-RUN
    period = 5;
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_seed = 8'hA5; cfg_reps = 8'd2;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ready", cfg_ready, 1);
    check("mid_rst_load_n", lfsr_load_n, 1);
    check("mid_rst_cen", lfsr_cen, 0);
    check("mid_rst_data", lfsr_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_irq", irq, 0);
    $display("reset mid-run busy=%0d cen=%0d", busy, lfsr_cen);
    @(negedge clk) reset = 1'b1;

`ifdef LFSR_INTERVAL_CTRL_PAUSE_EN
    begin
      int bad_pause, seen_irq;
      bad_pause = 0; seen_irq = 0;
      period = 3;
      @(posedge clk); #1;
      cfg_valid = 1'b1; cfg_seed = 8'h42; cfg_reps = 8'd1;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      @(posedge clk); #1;
      pause = 1'b1; tc_force = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (lfsr_cen || rep_count != 0 || !busy) bad_pause++;
        @(posedge clk); #1;
      end
      pause = 1'b0; tc_force = 1'b0;
      for (int i = 0; i < 50 && seen_irq == 0; i++) begin
        @(negedge clk);
        if (irq) seen_irq = 1;
      end
      check("pause_hold", bad_pause, 0);
      check("pause_resume_irq", seen_irq, 1);
      check("pause_rep_count", rep_count, 1);
      @(negedge clk);
      $display("pause job rep_count=%0d irq_seen=%0d", rep_count, seen_irq);
    end
`endif

    // Randomized jobs
    for (int j = 0; j < 20; j++) begin
      p = $urandom_range(1, 6);
      if ($urandom_range(0, 5) == 0) begin
        r = 0;
        k = $urandom_range(0, 30);
      end else begin
        r = $urandom_range(1, 4);
        k = ($urandom_range(0, 2) == 0) ? $urandom_range(0, r * (p + 1)) : -1;
      end
      run_job(8'($urandom), 8'(r), p, k, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
